// File: rtl/dac_out_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_out_pkg
// Brief    : Shared types, mode codes and mode sanitiser for dac_out_mux.
// Revision : 1.0
// ============================================================================
package dac_out_pkg;

    typedef enum logic [1:0] {
        MUTE     = 2'd0,
        FADE_IN  = 2'd1,
        RUN      = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    localparam logic [7:0] MODE_MUTE       = 8'd0;
    localparam int         MODE_BYPASS_BIT = 8;

    // Codes above the number of sources fold onto mute.
    function automatic logic [7:0] sanitise_mode(input logic [7:0] code, input int nsrc);
        return (int'(code) > nsrc) ? MODE_MUTE : code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_out_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_out_mux_if
// Brief    : Control, source and DAC-side signal bundle for dac_out_mux.
// Revision : 1.0
// ============================================================================
interface dac_out_mux_if #(
    parameter int DW   = 16,
    parameter int GW   = 32,
    parameter int NSRC = 4
);
    logic        [8:0]       i_mode;
    logic signed [GW-1:0]    i_gain;
    logic        [NSRC*DW-1:0] i_src;
    logic                    i_sat_clr;
    logic signed [DW-1:0]    o_dac_data;
    logic                    o_sat;
    logic                    o_busy;
    logic        [7:0]       o_active;

    modport master (
        output i_mode, i_gain, i_src, i_sat_clr,
        input  o_dac_data, o_sat, o_busy, o_active
    );

    modport slave (
        input  i_mode, i_gain, i_src, i_sat_clr,
        output o_dac_data, o_sat, o_busy, o_active
    );
endinterface
`default_nettype wire

// File: rtl/dac_out_mux_sat_shift.sv
`default_nettype none
// ============================================================================
// Module   : sat_shift
// Brief    : Arithmetic (floor) right shift followed by signed clamp to OW bits.
// Revision : 1.0
// ============================================================================
module sat_shift #(
    parameter int IW = 48,
    parameter int OW = 16,
    parameter int SH = 30
) (
    input  logic signed [IW-1:0] i_d,
    output logic signed [OW-1:0] o_q,
    output logic                 o_sat
);
    localparam logic signed [IW-1:0] c_MAX = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] c_MIN = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [IW-1:0] w_sh;

    always_comb begin
        w_sh  = i_d >>> SH;
        o_sat = 1'b0;
        o_q   = w_sh[OW-1:0];
        if (w_sh > c_MAX) begin
            o_q   = c_MAX[OW-1:0];
            o_sat = 1'b1;
        end else if (w_sh < c_MIN) begin
            o_q   = c_MIN[OW-1:0];
            o_sat = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/dac_out_mux.sv
`default_nettype none
// ============================================================================
// Module   : dac_out_mux
// Brief    : DAC source select, saturating gain and linear fade on mode change.
// Revision : 1.0
// ============================================================================
module dac_out_mux
    import dac_out_pkg::*;
#(
    parameter int DW   = 16,
    parameter int GW   = 32,
    parameter int FRAC = 30,
    parameter int NSRC = 4,
    parameter int RS   = 8
) (
    input  logic          clk,
    input  logic          rst,
    dac_out_mux_if.slave  bus
);
    localparam int         c_PW       = DW + GW;
    localparam int         c_EW       = DW + RS + 2;
    localparam logic [RS:0] c_ENV_FULL = {1'b1, {RS{1'b0}}};

    state_t      r_state, w_state_nx;
    logic [RS:0] r_env, w_env_nx;
    logic [7:0]  r_active, w_active_nx;
    logic        r_busy, w_busy_nx;
    logic [7:0]  w_tgt;

    assign w_tgt = sanitise_mode(bus.i_mode[7:0], NSRC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MUTE;
            r_env    <= '0;
            r_active <= MODE_MUTE;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_env    <= w_env_nx;
            r_active <= w_active_nx;
            r_busy   <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_env_nx    = r_env;
        w_active_nx = r_active;
        case (r_state)
            MUTE: begin
                w_env_nx = '0;
                if (w_tgt != MODE_MUTE) begin
                    w_active_nx = w_tgt;
                    w_state_nx  = FADE_IN;
                end
            end
            FADE_IN: begin
                if (w_tgt != r_active) begin
                    w_state_nx = FADE_OUT;
                end else begin
                    w_env_nx = r_env + 1'b1;
                    if (w_env_nx == c_ENV_FULL) w_state_nx = RUN;
                end
            end
            RUN: begin
                w_env_nx = c_ENV_FULL;
                if (w_tgt != r_active) w_state_nx = FADE_OUT;
            end
            FADE_OUT: begin
                // Target is only committed once the envelope has fully closed.
                if (r_env == '0) begin
                    w_active_nx = w_tgt;
                    w_state_nx  = (w_tgt != MODE_MUTE) ? FADE_IN : MUTE;
                end else begin
                    w_env_nx = r_env - 1'b1;
                end
            end
            default: w_state_nx = MUTE;
        endcase
        w_busy_nx = (w_state_nx == FADE_IN) || (w_state_nx == FADE_OUT);
    end

    // S1: source select (zero when muted) and gain multiply / bypass alignment.
    logic signed [DW-1:0]   w_src;
    logic signed [c_PW-1:0] w_src_ext, w_gain_ext, w_mul, w_byp;
    logic signed [c_PW-1:0] r_p;
    logic        [RS:0]     r_env1;

    always_comb begin
        w_src = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (r_active == 8'(k + 1)) w_src = bus.i_src[k*DW +: DW];
        end
    end

    assign w_src_ext  = {{GW{w_src[DW-1]}}, w_src};
    assign w_gain_ext = {{DW{bus.i_gain[GW-1]}}, bus.i_gain};
    assign w_mul      = w_src_ext * w_gain_ext;
    assign w_byp      = {{(GW-FRAC){w_src[DW-1]}}, w_src, {FRAC{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p    <= '0;
            r_env1 <= '0;
        end else begin
            r_p    <= bus.i_mode[MODE_BYPASS_BIT] ? w_byp : w_mul;
            r_env1 <= r_env;
        end
    end

    // S2: rescale and clamp; sticky flag where a new clamp beats a clear.
    logic signed [DW-1:0] w_q, r_q;
    logic                 w_clamp, r_sat;
    logic        [RS:0]   r_env2;

    sat_shift #(.IW(c_PW), .OW(DW), .SH(FRAC)) u_sat_shift (
        .i_d   (r_p),
        .o_q   (w_q),
        .o_sat (w_clamp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_env2 <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_q    <= w_q;
            r_env2 <= r_env1;
            if (w_clamp)            r_sat <= 1'b1;
            else if (bus.i_sat_clr) r_sat <= 1'b0;
        end
    end

    // S3: envelope scaling; the bit slice at RS is a floor division by 2^RS.
    logic signed [c_EW-1:0] w_q_ext, w_env_ext, w_prod;
    logic signed [DW-1:0]   r_dac;
    logic                   w_unused_prod;

    assign w_q_ext       = {{(RS+2){r_q[DW-1]}}, r_q};
    assign w_env_ext     = {{(DW+1){1'b0}}, r_env2};
    assign w_prod        = w_q_ext * w_env_ext;
    assign w_unused_prod = ^w_prod[c_EW-1:DW+RS];

    always_ff @(posedge clk) begin
        if (rst) r_dac <= '0;
        else     r_dac <= w_prod[RS +: DW];
    end

    assign bus.o_dac_data = r_dac;
    assign bus.o_sat      = r_sat;
    assign bus.o_busy     = r_busy;
    assign bus.o_active   = r_active;
endmodule
`default_nettype wire

// File: tb/tb_dac_out_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_out_mux
// Brief    : Scoreboard bench for dac_out_mux against a fade/gain reference model.
// Revision : 1.0
// ============================================================================
module tb_dac_out_mux;
    localparam int DW   = 16;
    localparam int GW   = 32;
    localparam int FRAC = 30;
    localparam int NSRC = 4;
    localparam int RS   = 8;
    localparam int FULL = 1 << RS;
    localparam longint MAXV = (64'sd1 <<< (DW-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (DW-1));

    typedef struct {
        int busy;
        int active;
        int sat;
    } stat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dac_out_mux_if #(.DW(DW), .GW(GW), .NSRC(NSRC)) bus ();

    dac_out_mux #(.DW(DW), .GW(GW), .FRAC(FRAC), .NSRC(NSRC), .RS(RS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    q_data[$];
    stat_t q_stat[$];
    int    n_vec = 0;
    int    n_bad = 0;
    bit    started = 1'b0;

    // Reference model: envelope level, selected source, closing flag, sat flag.
    int m_env, m_active, m_sat, m_clamp_prev;
    bit m_closing;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_sample(output int d, output int c);
        longint s, q;
        logic [DW-1:0] raw;
        c = 0;
        q = 0;
        if (m_active != 0) begin
            raw = bus.i_src[(m_active-1)*DW +: DW];
            s = longint'($signed(raw));
            if (bus.i_mode[8]) q = s;
            else               q = (s * longint'(bus.i_gain)) >>> FRAC;
            if (q > MAXV) begin q = MAXV; c = 1; end
            if (q < MINV) begin q = MINV; c = 1; end
        end
        d = int'((q * m_env) >>> RS);
    endtask

    task automatic model_step();
        int tgt;
        tgt = int'(bus.i_mode[7:0]);
        if (tgt > NSRC) tgt = 0;
        if (m_closing) begin
            if (m_env == 0) begin
                m_active  = tgt;
                m_closing = 1'b0;
            end else begin
                m_env--;
            end
        end else if (m_active == 0) begin
            if (tgt != 0) m_active = tgt;
        end else if (tgt != m_active) begin
            m_closing = 1'b1;
        end else if (m_env < FULL) begin
            m_env++;
        end
    endtask

    task automatic tick();
        stat_t st;
        int d, c;
        if (rst) begin
            m_env = 0; m_active = 0; m_sat = 0; m_clamp_prev = 0; m_closing = 1'b0;
            q_data.delete();
            repeat (3) q_data.push_back(0);
            st = '{0, 0, 0};
        end else begin
            model_sample(d, c);
            q_data.push_back(d);
            m_sat = (m_clamp_prev != 0) ? 1 : (bus.i_sat_clr ? 0 : m_sat);
            m_clamp_prev = c;
            model_step();
            st.busy   = (m_closing || (m_active != 0 && m_env < FULL)) ? 1 : 0;
            st.active = m_active;
            st.sat    = m_sat;
        end
        q_stat.push_back(st);
        started = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        int    d;
        stat_t s;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (q_data.size() == 0 || q_stat.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL scoreboard_empty: data=%0d stat=%0d entries", q_data.size(), q_stat.size());
                end else begin
                    d = q_data.pop_front();
                    s = q_stat.pop_front();
                    check("dac_data", int'(bus.o_dac_data), d);
                    check("busy",     int'(bus.o_busy),     s.busy);
                    check("active",   int'(bus.o_active),   s.active);
                    check("sat",      int'(bus.o_sat),      s.sat);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.i_mode = '0;
        bus.i_gain = '0;
        bus.i_src = '0;
        bus.i_sat_clr = 1'b0;
        @(negedge clk);
        do_reset(2);

        // Fade in on source 1 at unity gain, then hold.
        bus.i_src[0 +: DW] = 16'sd256;
        bus.i_gain = 32'sh4000_0000;
        bus.i_mode = 9'd1;
        run(300);

        // Half gain on a negative odd sample (floor rounding).
        bus.i_gain = 32'sh2000_0000;
        bus.i_src[0 +: DW] = -16'sd1001;
        run(10);

        // Positive clamp, clear with no clamp, then clear during a clamp.
        bus.i_src[0 +: DW] = 16'sd20000;
        bus.i_gain = 32'sh7FFF_FFFF;
        run(6);
        bus.i_src[0 +: DW] = 16'sd100;
        bus.i_gain = 32'sh4000_0000;
        run(4);
        bus.i_sat_clr = 1'b1;
        run(1);
        bus.i_sat_clr = 1'b0;
        run(4);
        bus.i_src[0 +: DW] = 16'sd20000;
        bus.i_gain = 32'sh7FFF_FFFF;
        bus.i_sat_clr = 1'b1;
        run(6);
        bus.i_sat_clr = 1'b0;

        // Source switch 1 -> 2 from full envelope.
        bus.i_src[0 +: DW] = 16'sd256;
        bus.i_gain = 32'sh4000_0000;
        run(4);
        bus.i_src[DW +: DW] = -16'sd128;
        bus.i_mode = 9'd2;
        run(600);

        // Switch during fade-in at envelope 100.
        do_reset(1);
        bus.i_mode = 9'd1;
        run(101);
        bus.i_mode = 9'd2;
        run(400);

        // Out-of-range code mutes; reset in the middle of a fade.
        bus.i_mode = 9'd7;
        run(300);
        bus.i_mode = 9'd1;
        run(50);
        do_reset(1);
        run(5);

        // Randomised traffic: sparse mode changes, bypass, gains, clears.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                if ($urandom_range(0, 7) == 0) bus.i_mode = 9'($urandom);
                else bus.i_mode = {1'($urandom_range(0, 1)), 8'($urandom_range(0, NSRC))};
            end
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0) bus.i_gain = $signed($urandom);
                else                           bus.i_gain = $signed($urandom) >>> 2;
            end
            bus.i_src = {$urandom, $urandom};
            bus.i_sat_clr = ($urandom_range(0, 7) == 0);
            if (i == 1500) do_reset(1);
            tick();
        end
        bus.i_sat_clr = 1'b0;
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dac_out_mux.md
Name: dac_out_mux

Overview:
- Parametrised DAC output stage: selects one of NSRC signed sample sources (DDS, IFFT, ...) and applies a fixed-point gain with saturation rather than truncation.
- Applies a linear fade envelope on every source change, so mode switches never glitch the DAC.
- Sits between the signal generators and the DAC interface; mode and gain come from control registers.

Parameters:
- DW, 16, sample and DAC data width
- GW, 32, signed gain word width
- FRAC, 30, fractional bits of the gain word (1.0 = 2^FRAC)
- NSRC, 4, number of input sources
- RS, 8, ramp shift; fade length = 2^RS cycles

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_mode  in  9  [7:0] source code: 0 = mute, k = source k-1 (1..NSRC); codes >NSRC are treated as 0. [8] = gain bypass (unity)
- i_gain  in  GW  signed gain, Q(GW-FRAC).FRAC
- i_src  in  NSRC*DW  signed sources, source k at [k*DW +: DW]
- i_sat_clr  in  1  clears o_sat
- o_dac_data  out  DW  signed DAC sample
- o_sat  out  1  sticky saturation flag
- o_busy  out  1  high while fading (FADE_OUT/FADE_IN)
- o_active  out  8  source code currently driving the output

Behaviour:
- Reset:
  - o_dac_data=0, o_sat=0, o_busy=0, o_active=0.
  - env=0, state=MUTE, all pipeline registers=0.
  - Reset mid-fade aborts immediately.
- Datapath, 3-cycle latency from i_src/i_gain to o_dac_data:
  - S1: p = src[active] * i_gain, signed, DW+GW bits. With bypass, p = src << FRAC.
  - S2: q = p >>> FRAC (arithmetic, floor), then clamp to [-2^(DW-1), 2^(DW-1)-1]. A clamp sets o_sat.
  - S3: o_dac_data = (q * env) >>> RS (floor). env = 2^RS gives exact q.
- Envelope and mode are sampled at S1 and pipelined alongside the data, so each output sample uses a consistent env/source pair.
- i_gain changes take effect immediately (no ramp).
- State machine, with tgt = sanitised i_mode[7:0]:
  - MUTE: env=0. If tgt!=0: active<=tgt, go to FADE_IN.
  - FADE_IN: env+=1 per cycle. When env reaches 2^RS, go to RUN. If tgt!=active, go to FADE_OUT starting from the current env (no jump).
  - RUN: env=2^RS. If tgt!=active, go to FADE_OUT.
  - FADE_OUT: env-=1 per cycle. tgt may change freely; only its value at env==0 matters. On the cycle env==0: active<=tgt, then go to FADE_IN if tgt!=0, else MUTE (active=0).
  - If tgt returns to the old active value during FADE_OUT, the fade still completes to 0 and then fades back in.
  - A bypass-bit change alone does not trigger a fade.
- o_busy = state in {FADE_IN, FADE_OUT}, registered with state. o_active = active.
- o_sat: set on any S2 clamp; cleared by i_sat_clr. If set and clear occur in the same cycle, set wins.
- No output underflow: the mute path drives exact 0.

Decomposition:
- Package dac_out_pkg holds:
  - state enum {MUTE, FADE_IN, RUN, FADE_OUT}
  - MODE_MUTE=0, MODE_BYPASS_BIT=8
  - the mode-sanitise function (code>NSRC -> 0)
- One sub-module, sat_shift: parametrised arithmetic right shift plus clamp, with a sat output. Used in S2 and reusable elsewhere.

Test Plan:
- Reset, then mode 1, src0=256, gain=0x4000_0000 -> o_busy high 256 cycles. o_dac_data rises by 1 per cycle from 0, reaches 256 and holds. o_active=1.
- RUN mode 1, gain=0x2000_0000, src0=-1001 -> o_dac_data=-501 (floor) 3 cycles after the gain change, o_sat=0.
- src0=20000, gain=0x7FFF_FFFF -> o_dac_data=32767, o_sat=1. Pulse i_sat_clr with no further clamps -> o_sat=0. Clear during a clamp -> o_sat stays 1.
- RUN mode 1 (out 256), switch i_mode to 2 (src1=-128) -> output ramps 256 down to 0 over 256 cycles, o_active changes to 2 at env 0, then ramps to -128.
- Mode 1 to 2 at env=100 during FADE_IN -> fade out starts from 100, no step larger than 1 LSB-scale in the output.
- i_mode=7 (>NSRC) from RUN -> fade to 0, state MUTE, o_active=0. Assert rst mid-fade -> next cycle all outputs 0.
